// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined FP adder between NUM_REQ requesters,
// with in-order, credit-protected result return. Optional FPU_ARB_PERF_EN adds grant counters.
module fpu_add_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned PIPE_LAT   = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*32-1:0]   req_a_i,
  input  logic [NUM_REQ*32-1:0]   req_b_i,
  output logic                    add_valid_o,
  output logic [31:0]             add_a_o,
  output logic [31:0]             add_b_o,
  input  logic                    add_valid_i,
  input  logic [31:0]             add_res_i,
  output logic [NUM_REQ-1:0]      resp_valid_o,
  input  logic [NUM_REQ-1:0]      resp_ready_i,
  output logic [31:0]             resp_res_o,
  output logic                    err_o
`ifdef FPU_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]   perf_grant_cnt_o
`endif
);

  localparam int unsigned FpW = 32;
  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;

  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  used_q, used_d;
  logic           found, grant, credit_ok;
  logic [IdW-1:0] gnt_id;
  logic [FpW-1:0] sel_a, sel_b;

  logic [PIPE_LAT-1:0] tag_vld_q;
  logic [IdW-1:0]      tag_id_q [PIPE_LAT];
  logic                push, pop, fifo_empty;
  logic [IdW-1:0]      head_id;

  logic [FpW-1:0] fifo_res_q [FIFO_DEPTH];
  logic [IdW-1:0] fifo_id_q  [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           err_q;

  // Round-robin scan: first pass covers rr_ptr..NUM_REQ-1, second pass wraps to 0.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req_valid_i[j] && (j >= int'(rr_ptr_q))) begin
        found  = 1'b1;
        gnt_id = IdW'(j);
        sel_a  = req_a_i[j*FpW +: FpW];
        sel_b  = req_b_i[j*FpW +: FpW];
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req_valid_i[j]) begin
        found  = 1'b1;
        gnt_id = IdW'(j);
        sel_a  = req_a_i[j*FpW +: FpW];
        sel_b  = req_b_i[j*FpW +: FpW];
      end
    end
  end

  // Credits count everything issued and not yet popped, so the FIFO can never overflow.
  assign credit_ok = (used_q < CW'(FIFO_DEPTH));
  assign grant     = found && credit_ok && !rst_i;

  always_comb begin
    req_ready_o = '0;
    if (grant) begin
      req_ready_o[gnt_id] = 1'b1;
    end
    add_valid_o = grant;
    add_a_o     = grant ? sel_a : '0;
    add_b_o     = grant ? sel_b : '0;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (gnt_id == IdW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_vld_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_id_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0] <= grant;
      tag_id_q[0]  <= gnt_id;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  // The tag line, not add_valid_i, decides what gets pushed; a disagreement is only flagged.
  assign push = tag_vld_q[PIPE_LAT-1];

  assign fifo_empty = (count_q == '0);
  assign head_id    = fifo_id_q[rd_ptr_q];

  always_comb begin
    resp_valid_o = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      resp_valid_o[j] = !fifo_empty && (head_id == IdW'(j));
    end
    resp_res_o = fifo_empty ? '0 : fifo_res_q[rd_ptr_q];
  end

  assign pop = |(resp_valid_o & resp_ready_i);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    used_d = used_q;
    if (grant && !pop) begin
      used_d = used_q + CW'(1);
    end else if (pop && !grant) begin
      used_d = used_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_res_q[wr_ptr_q] <= add_res_i;
      fifo_id_q[wr_ptr_q]  <= tag_id_q[PIPE_LAT-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      used_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      used_q   <= used_d;
      count_q  <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (add_valid_i != push) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;

`ifdef FPU_ARB_PERF_EN
  logic [15:0] perf_cnt_q [NUM_REQ];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        perf_cnt_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req_ready_o[j] && (perf_cnt_q[j] != 16'hFFFF)) begin
          perf_cnt_q[j] <= perf_cnt_q[j] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    perf_grant_cnt_o = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      perf_grant_cnt_o[j*16 +: 16] = perf_cnt_q[j];
    end
  end
`endif

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Bench for fpu_add_arbiter: stub FP adder plus a transaction-level model (queue of pending
// operations with their visibility cycle) checked every cycle, with directed scenarios.
module tb_fpu_add_arbiter;
  localparam int N     = 2;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0]     opa [N];
  logic [31:0]     opb [N];
  logic [N*32-1:0] req_a, req_b;
  logic            add_valid_o, add_valid_i, err;
  logic [31:0]     add_a, add_b, add_res, resp_res;
  logic            force_v;

  assign req_a = {opa[1], opa[0]};
  assign req_b = {opb[1], opb[0]};

  fpu_add_arbiter #(.NUM_REQ(N), .PIPE_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b),
    .add_valid_o(add_valid_o), .add_a_o(add_a), .add_b_o(add_b),
    .add_valid_i(add_valid_i), .add_res_i(add_res),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_res_o(resp_res),
    .err_o(err)
  );

  function automatic logic [63:0] s2d(logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return {x[31], 63'd0};
    e = {3'd0, x[30:23]} + 11'd896;
    return {x[31], e, x[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    real ra, rb;
    logic [63:0] d;
    logic [10:0] e;
    ra = $bitstoreal(s2d(a));
    rb = $bitstoreal(s2d(b));
    d  = $realtobits(ra + rb);
    if (d[62:0] == 63'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] r;
    r = $urandom;
    r[30:23] = 8'($urandom_range(100, 150));
    return r;
  endfunction

  // Stub adder: fixed LAT-cycle pipeline, flushed by the shared reset.
  logic        sv_q [LAT];
  logic [31:0] sr_q [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) sv_q[i] <= 1'b0;
    end else begin
      sv_q[0] <= add_valid_o;
      sr_q[0] <= fadd(add_a, add_b);
      for (int i = 1; i < LAT; i++) begin
        sv_q[i] <= sv_q[i-1];
        sr_q[i] <= sr_q[i-1];
      end
    end
  end
  assign add_valid_i = sv_q[LAT-1] | force_v;
  assign add_res     = sr_q[LAT-1];

  typedef struct {
    int          id;
    logic [31:0] res;
    int          vis;
  } op_t;

  op_t  pend [$];
  int   rr, cyc, checks, errors, gnt_seen;
  logic err_exp;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    rr      = 0;
    err_exp = 1'b0;
  endtask

  // One clock cycle: predict, compare, clock, then advance the model.
  task automatic step();
    int          g;
    logic [N-1:0] e_rdy, e_rv;
    logic [31:0] ea, eb, er;
    bit          do_pop, arrival;
    #2;
    g = -1;
    if (!rst && pend.size() < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (rr + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    e_rdy = (g >= 0) ? N'(1 << g) : '0;
    ea    = (g >= 0) ? opa[g] : 32'd0;
    eb    = (g >= 0) ? opb[g] : 32'd0;
    e_rv  = '0;
    er    = 32'd0;
    if (pend.size() > 0 && pend[0].vis <= cyc) begin
      e_rv = N'(1 << pend[0].id);
      er   = pend[0].res;
    end
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("add_valid", 32'(add_valid_o), (g >= 0) ? 32'd1 : 32'd0);
    chk("add_a", add_a, ea);
    chk("add_b", add_b, eb);
    chk("resp_valid", 32'(resp_valid), 32'(e_rv));
    chk("resp_res", resp_res, er);
    chk("err", 32'(err), 32'(err_exp));
    if (add_valid_o === 1'b1) gnt_seen++;
    do_pop  = (e_rv & resp_ready) != '0;
    arrival = 1'b0;
    foreach (pend[i]) if (pend[i].vis == cyc + 1) arrival = 1'b1;
    @(posedge clk);
    if (force_v && !arrival) err_exp = 1'b1;
    if (do_pop) void'(pend.pop_front());
    if (g >= 0) begin
      pend.push_back('{g, fadd(ea, eb), cyc + LAT + 1});
      rr = (g + 1) % N;
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    req_valid  = '0;
    resp_ready = '1;
    repeat (12) step();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; gnt_seen = 0;
    req_valid = '0; resp_ready = '0; force_v = 1'b0;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    step();

    // Basic add: 1.0 + 2.0 from requester 0, result visible 4 cycles after issue.
    opa[0] = 32'h3F80_0000;
    opb[0] = 32'h4000_0000;
    req_valid = 2'b01;
    step();
    req_valid = '0;
    repeat (3) step();
    #1;
    chk("basic_resp_valid", 32'(resp_valid), 32'h1);
    chk("basic_resp_res", resp_res, 32'h4040_0000);
    resp_ready = 2'b01;
    step();
    drain();

    // Round robin with both requesters streaming.
    opa[1] = rnd_fp(); opb[1] = rnd_fp();
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    repeat (20) step();
    drain();

    // Credit stall: exactly DEPTH grants, then one pop buys one more grant.
    resp_ready = '0;
    req_valid  = 2'b01;
    gnt_seen   = 0;
    repeat (8) step();
    chk("credit_grants", 32'(gnt_seen), 32'(DEPTH));
    resp_ready = 2'b01;
    gnt_seen   = 0;
    step();
    resp_ready = '0;
    repeat (3) step();
    chk("credit_regrant", 32'(gnt_seen), 32'd1);
    drain();

    // Head-of-line blocking: id1's result waits behind id0's.
    resp_ready = 2'b10;
    req_valid  = 2'b01;
    step();
    req_valid  = 2'b10;
    step();
    req_valid  = '0;
    repeat (8) step();
    chk("hol_head", 32'(resp_valid), 32'h1);
    drain();

    // Protocol error: spurious add_valid_i with nothing in flight; err_o must stick.
    force_v = 1'b1;
    step();
    force_v = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_valid  = N'($urandom);
      resp_ready = N'($urandom);
      opa[0] = rnd_fp(); opb[0] = rnd_fp(); opa[1] = rnd_fp(); opb[1] = rnd_fp();
      step();
    end
    chk("err_sticky", 32'(err), 32'd1);
    drain();

    // Async reset mid-flight with work queued and in the adder.
    resp_ready = '0;
    req_valid  = 2'b01;
    repeat (3) step();
    req_valid  = '0;
    step();
    req_valid  = 2'b01;
    #1 rst = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_add_valid", 32'(add_valid_o), 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_res", resp_res, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    gnt_seen = 0;
    step();
    chk("post_rst_grant", 32'(gnt_seen), 32'd1);
    drain();

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      req_valid  = N'($urandom);
      resp_ready = N'($urandom);
      for (int k = 0; k < N; k++) begin
        opa[k] = rnd_fp();
        opb[k] = rnd_fp();
      end
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
